xadc_drp_seq: RTL

XADC_DRP_SEQ -- requirements
Module: xadc_drp_seq

---
 rtl/xadc_drp_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/xadc_drp_seq.sv
// xadc_drp_seq: on each XADC end-of-sequence, reads two DRP status words and publishes them together.
// Optional macro XADC_DRP_TIMEOUT_EN: abort a read whose DRDY does not return within TIMEOUT_CYC cycles.
module xadc_drp_seq #(
    parameter logic [6:0] ADDR_A      = 7'h10,
    parameter logic [6:0] ADDR_B      = 7'h12,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic        DCLK,
    input  logic        RESET,
    input  logic        EOS,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        DEN,
    output logic        DWE,
    output logic [6:0]  DADDR,
    output logic [15:0] DI,
    output logic [15:0] MEASURED_AUX_A,
    output logic [15:0] MEASURED_AUX_B,
    output logic        DATA_VALID,
    output logic        BUSY,
    output logic        OVERRUN
);
    typedef enum logic [2:0] {IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, COMMIT} state_t;

    state_t      state_q, state_d;
    logic        den_q, den_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] shadow_a_q, shadow_a_d;
    logic [15:0] shadow_b_q, shadow_b_d;
    logic [15:0] meas_a_q, meas_a_d;
    logic [15:0] meas_b_q, meas_b_d;
    logic        dv_q, dv_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;
    logic        pend_q, pend_d;
    logic        busy;
    logic        timeout;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef XADC_DRP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;

    // Count consecutive WAIT_* cycles without DRDY; the count restarts on every exit.
    always_comb begin
        waiting = (state_q == WAIT_A) || (state_q == WAIT_B);
        timeout = waiting && !DRDY && (cnt_q == CW'(TIMEOUT_CYC - 1));
        cnt_d   = (waiting && !DRDY && !timeout) ? cnt_q + 1'b1 : '0;
    end

    // Timeout counter register.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Sequencer next state, shadow capture, commit and request bookkeeping.
    always_comb begin
        busy       = state_q != IDLE;
        state_d    = state_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        meas_a_d   = meas_a_q;
        meas_b_d   = meas_b_q;
        dv_d       = 1'b0;
        case (state_q)
            IDLE:    state_d = (EOS || pend_q) ? REQ_A : IDLE;
            REQ_A:   state_d = WAIT_A;
            WAIT_A: begin
                if (DRDY) begin
                    shadow_a_d = DO;
                    state_d    = REQ_B;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            REQ_B:   state_d = WAIT_B;
            WAIT_B: begin
                if (DRDY) begin
                    shadow_b_d = DO;
                    state_d    = COMMIT;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                meas_a_d = shadow_a_q;
                meas_b_d = shadow_b_q;
                dv_d     = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A pending request is always consumed when IDLE is left; an EOS arriving then re-arms it.
        pend_d  = (pend_q && busy) || (EOS && (busy || pend_q));
        ovr_d   = ovr_q || (EOS && busy && pend_q);
        den_d   = (state_d == REQ_A) || (state_d == REQ_B);
        daddr_d = (state_d == REQ_A) ? ADDR_A : (state_d == REQ_B) ? ADDR_B : daddr_q;
        busy_d  = state_d != IDLE;
    end

    // All sequencer state and registered outputs.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            den_q      <= 1'b0;
            daddr_q    <= 7'h00;
            shadow_a_q <= 16'h0000;
            shadow_b_q <= 16'h0000;
            meas_a_q   <= 16'h0000;
            meas_b_q   <= 16'h0000;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            den_q      <= den_d;
            daddr_q    <= daddr_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            meas_a_q   <= meas_a_d;
            meas_b_q   <= meas_b_d;
            dv_q       <= dv_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            pend_q     <= pend_d;
        end
    end

    assign DEN            = den_q;
    assign DWE            = 1'b0;
    assign DADDR          = daddr_q;
    assign DI             = 16'h0000;
    assign MEASURED_AUX_A = meas_a_q;
    assign MEASURED_AUX_B = meas_b_q;
    assign DATA_VALID     = dv_q;
    assign BUSY           = busy_q;
    assign OVERRUN        = ovr_q;
endmodule
